traffic_gen_master: RTL
=======================

Name: traffic_gen_master

Overview:
- Parametrised bus-traffic generator on the device side of master_port.
- Issues a programmable sequence of 1..NUM_TXN transfers. Addresses are ADDR_BASE + i*ADDR_STRIDE; write data is a seeded pattern.
- Modes: write, read, or write-then-readback-verify.
- Read data lands in an internal buffer readable by the test harness; mismatches are counted.
- Used for bring-up and soak tests of the serial bus, arbiter and slaves.

Parameters:
- ADDR_WIDTH, 16, device address width.
- DATA_WIDTH, 8, data width.
- NUM_TXN, 8, max transfers per run; also read-buffer depth; >=2.
- ADDR_BASE, 16'h0000, address of transfer 0.
- ADDR_STRIDE, 16'h1001, address increment per transfer.
- CNT_WIDTH, 8, width of err_count and txn_count.
- TIMEOUT_CYCLES, 1024, watchdog limit, used only with TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset.
- start  input  1  one-cycle start request, sampled in IDLE only.
- mode  input  2  00 read, 01 write, 10 write+verify, 11 treated as 01.
- len  input  $clog2(NUM_TXN+1)  transfer count; values > NUM_TXN are clamped to NUM_TXN.
- seed  input  DATA_WIDTH  pattern seed.
- daddr  output  ADDR_WIDTH  address to master_port.
- dwdata  output  DATA_WIDTH  write data to master_port.
- dmode  output  1  0 read, 1 write.
- dvalid  output  1  request strobe.
- dready  input  1  master_port idle/complete.
- drdata  input  DATA_WIDTH  read data from master_port.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse when a run completes.
- err_count  output  CNT_WIDTH  verify mismatches, saturating.
- txn_count  output  CNT_WIDTH  completed transfers this run, saturating.
- buf_idx  input  $clog2(NUM_TXN)  read-buffer index.
- buf_data  output  DATA_WIDTH  combinational rbuf[buf_idx].

Behaviour:
- Reset (clk and rstn as decided; synchronous, active-low):
  - state=IDLE; dvalid=0, dmode=0, daddr=ADDR_BASE, dwdata=0, done=0.
  - err_count=0, txn_count=0; rbuf contents undefined.
  - Reset asserted mid-run aborts at the next edge: dvalid is low on the following cycle, no done pulse.
- States: IDLE, ISSUE, WAIT, NEXT, FIN.
- IDLE:
  - On start with len==0: go to FIN; no transfers.
  - Otherwise latch mode, eff_len and seed; clear err_count, txn_count, idx and pass; go to ISSUE.
  - pass=0 is the write pass for modes 01/10 and the read pass for mode 00.
  - start outside IDLE is ignored.
- ISSUE:
  - Drive daddr = ADDR_BASE + idx*ADDR_STRIDE, mod 2^ADDR_WIDTH.
  - dwdata = seed + idx, mod 2^DATA_WIDTH.
  - dmode = 1 on a write pass, else 0.
  - dvalid=1 for exactly this one cycle; next state is WAIT.
- WAIT:
  - dvalid=0; daddr, dwdata and dmode held stable.
  - dready is ignored on the first WAIT cycle (master_port latency guard).
  - From the second WAIT cycle, dready=1 completes the transfer:
    - txn_count++.
    - On a read pass, rbuf[idx] <= drdata.
    - In mode 10, drdata is also compared with seed+idx; on mismatch err_count++, saturating at all-ones.
  - Next state is NEXT.
- NEXT:
  - If idx == eff_len-1:
    - Mode 10 with pass=0: pass=1, idx=0, go to ISSUE (readback pass).
    - Otherwise go to FIN.
  - Else idx++ and go to ISSUE.
- FIN: done=1 for one cycle, then IDLE. Counters hold until the next start.
- Cycle counts:
  - Back-to-back transfers need at least 4 cycles each (ISSUE, 2×WAIT, NEXT).
  - Minimum run latency from start to done is 4*eff_len+2 cycles; mode 10 costs double.
- Boundaries:
  - Address and data arithmetic wraps silently.
  - len > NUM_TXN is clamped.
  - txn_count in mode 10 reaches 2*eff_len.
  - buf_idx >= NUM_TXN returns 0.

Optional Feature:
- Macro: TRAFFIC_GEN_TIMEOUT_EN.
- Defined:
  - A watchdog counts WAIT cycles. When it reaches TIMEOUT_CYCLES without dready, the run aborts to FIN.
  - Adds output port timeout (1 bit): set on abort, held until the next start.
  - done still pulses; txn_count excludes the aborted transfer.
- Undefined: no watchdog, no timeout port; WAIT lasts indefinitely.

Test Plan:
- Write, mode=01, len=3, seed=8'h10, dready high from the second WAIT cycle -> dvalid pulses at daddr 0000/1001/2002 with dwdata 10/11/12, dmode=1; done after 14 cycles; txn_count=3, err_count=0.
- Read, mode=00, len=2, slave returns 8'hA5 then 8'h5A -> dmode=0; buf_data[0]=A5, buf_data[1]=5A; done pulses once.
- Verify, mode=10, len=4, seed=8'hF0, mirror slave corrupts idx 2 -> 8 transfers; dwdata F0..F3; txn_count=8, err_count=1; buf_data[2] shows the corrupted value.
- Edges: len=0 -> done on the 2nd cycle, no dvalid. len=NUM_TXN+3 -> exactly NUM_TXN transfers. start held during run -> no restart. With seed=8'hFF, idx1 data wraps to 8'h00.
- Reset: rstn low during WAIT of transfer 1 -> dvalid=0, ready=1, counters 0 next cycle, no done; a new run then completes normally.
- TRAFFIC_GEN_TIMEOUT_EN, dready stuck low -> abort after TIMEOUT_CYCLES WAIT cycles; timeout=1, done pulse, txn_count=0.

Source files
------------

// File: rtl/traffic_gen_master.sv
// traffic_gen_master: write/read/write+verify bus-traffic generator; watchdog option via TRAFFIC_GEN_TIMEOUT_EN.
// Latency: 4 cycles per transfer minimum (ISSUE, 2x WAIT, NEXT) plus 2 per run; verify runs two passes.
// Backpressure: one request outstanding; WAIT holds until dready (second WAIT cycle on) or watchdog expiry.
module traffic_gen_master #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    NUM_TXN        = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE      = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE    = 16'h1001,
    parameter int                    CNT_WIDTH      = 8,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic [$clog2(NUM_TXN+1)-1:0]   len,
    input  logic [DATA_WIDTH-1:0]          seed,
    output logic [ADDR_WIDTH-1:0]          daddr,
    output logic [DATA_WIDTH-1:0]          dwdata,
    output logic                           dmode,
    output logic                           dvalid,
    input  logic                           dready,
    input  logic [DATA_WIDTH-1:0]          drdata,
    output logic                           ready,
    output logic                           done,
    output logic [CNT_WIDTH-1:0]           err_count,
    output logic [CNT_WIDTH-1:0]           txn_count,
`ifdef TRAFFIC_GEN_TIMEOUT_EN
    output logic                           timeout,
`endif
    input  logic [$clog2(NUM_TXN)-1:0]     buf_idx,
    output logic [DATA_WIDTH-1:0]          buf_data
);

    localparam int                   LEN_W   = $clog2(NUM_TXN + 1);
    localparam int                   IDX_W   = $clog2(NUM_TXN);
    localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(NUM_TXN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FIN} state_t;
    state_t state, state_nxt;

    logic [LEN_W-1:0]      eff_len;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  pass;
    logic                  mode_rd;
    logic                  mode_vfy;
    logic                  wait_first;
    logic [DATA_WIDTH-1:0] rbuf [NUM_TXN];

    logic last_idx;
    logic xfer_done;
    logic rd_pass;
    logic run_go;
    logic wd_abort;

    assign last_idx  = (LEN_W'(idx) + LEN_W'(1)) == eff_len;
    assign rd_pass   = mode_rd || pass;
    assign xfer_done = (state == WAIT) && !wait_first && dready;
    assign run_go    = (state == IDLE) && start && (len != '0);

    assign dvalid = (state == ISSUE);
    assign ready  = (state == IDLE);
    assign done   = (state == FIN);

`ifdef TRAFFIC_GEN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // wd_cnt holds the number of WAIT cycles already spent, so the compare fires on cycle TIMEOUT_CYCLES
    assign wd_abort = (state == WAIT) && !xfer_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == ISSUE)
                wd_cnt <= '0;
            else if (state == WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            if ((state == IDLE) && start)
                timeout <= 1'b0;
            else if (wd_abort)
                timeout <= 1'b1;
        end
    end
`else
    assign wd_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? FIN : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (xfer_done)
                    state_nxt = NEXT;
                else if (wd_abort)
                    state_nxt = FIN;
            end
            NEXT:    state_nxt = (last_idx && !(mode_vfy && !pass)) ? FIN : ISSUE;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address and data advance incrementally, so daddr/dwdata are stable from ISSUE through WAIT
    always_ff @(posedge clk) begin
        if (!rstn) begin
            daddr      <= ADDR_BASE;
            dwdata     <= '0;
            dmode      <= 1'b0;
            eff_len    <= '0;
            idx        <= '0;
            seed_q     <= '0;
            pass       <= 1'b0;
            mode_rd    <= 1'b0;
            mode_vfy   <= 1'b0;
            wait_first <= 1'b0;
            err_count  <= '0;
            txn_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_go) begin
                        eff_len   <= (len > MAX_LEN) ? MAX_LEN : len;
                        mode_rd   <= (mode == 2'b00);
                        mode_vfy  <= (mode == 2'b10);
                        seed_q    <= seed;
                        pass      <= 1'b0;
                        idx       <= '0;
                        err_count <= '0;
                        txn_count <= '0;
                        daddr     <= ADDR_BASE;
                        dwdata    <= seed;
                        dmode     <= (mode != 2'b00);
                    end
                end
                ISSUE: wait_first <= 1'b1;
                WAIT: begin
                    wait_first <= 1'b0;
                    if (xfer_done) begin
                        if (txn_count != CNT_MAX)
                            txn_count <= txn_count + 1'b1;
                        if (mode_vfy && pass && (drdata != dwdata) && (err_count != CNT_MAX))
                            err_count <= err_count + 1'b1;
                    end
                end
                NEXT: begin
                    if (last_idx) begin
                        if (mode_vfy && !pass) begin
                            pass   <= 1'b1;
                            idx    <= '0;
                            daddr  <= ADDR_BASE;
                            dwdata <= seed_q;
                            dmode  <= 1'b0;
                        end
                    end else begin
                        idx    <= idx + 1'b1;
                        daddr  <= daddr + ADDR_STRIDE;
                        dwdata <= dwdata + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (xfer_done && rd_pass)
            rbuf[idx] <= drdata;
    end

    if ((1 << IDX_W) > NUM_TXN) begin : g_idx_guard
        assign buf_data = (buf_idx < IDX_W'(NUM_TXN)) ? rbuf[buf_idx] : '0;
    end else begin : g_idx_full
        assign buf_data = rbuf[buf_idx];
    end

endmodule
